sram_stream_reader: RTL and testbench

SRAM_STREAM_READER -- requirements
Module: sram_stream_reader

---
 rtl/sram_stream_reader_if.sv | 42 ++++
 rtl/sram_stream_reader.sv | 174 +++++++++++++++++
 tb/tb_sram_stream_reader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_stream_reader_if.sv
// ---------------------------------------------------------------------------
// sram_stream_reader_if
// Bundles the SRAM read port and the downstream valid/ready stream used by
// sram_stream_reader.
//   o_sram_cs    : SRAM read strobe (reader -> SRAM)
//   o_sram_addr  : SRAM read address (reader -> SRAM)
//   i_sram_rdata : SRAM read data, valid the cycle after o_sram_cs
//   o_valid      : stream word available (reader -> sink)
//   o_data       : stream word (reader -> sink)
//   i_ready      : sink accepts the word when o_valid && i_ready
// The master modport is the reader's view; the slave modport is the view of
// the SRAM plus sink side.
// ---------------------------------------------------------------------------
interface sram_stream_reader_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 16
) ();
  logic              o_sram_cs;
  logic [ADDR_W-1:0] o_sram_addr;
  logic [DATA_W-1:0] i_sram_rdata;
  logic              o_valid;
  logic [DATA_W-1:0] o_data;
  logic              i_ready;

  modport master (
    output o_sram_cs,
    output o_sram_addr,
    input  i_sram_rdata,
    output o_valid,
    output o_data,
    input  i_ready
  );

  modport slave (
    input  o_sram_cs,
    input  o_sram_addr,
    output i_sram_rdata,
    input  o_valid,
    input  o_data,
    output i_ready
  );
endinterface

// File: rtl/sram_stream_reader.sv
// ---------------------------------------------------------------------------
// sram_stream_reader
// Reads N_WORDS consecutive SRAM words starting at address 0 and presents
// them on a valid/ready stream through a 2-entry FIFO. A run starts when
// i_en is seen in IDLE and ends with a one-cycle done pulse once the last
// word has been accepted.
//
// Ports:
//   clk    : clock, all logic on the rising edge
//   rst    : synchronous active-high reset
//   i_en   : start request, only looked at in IDLE
//   bus    : sram_stream_reader_if.master (SRAM read port + output stream)
//   o_busy : high while in READ or DRAIN
//   done   : one-cycle pulse after the last word is accepted
//   o_sum  : (only with SRAM_STREAM_CHECKSUM_EN defined) 20-bit running sum
//            of the words accepted in the current run
//
// Optional feature macro: SRAM_STREAM_CHECKSUM_EN
// ---------------------------------------------------------------------------
module sram_stream_reader #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 16,
  parameter int N_WORDS = 65536
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_en,
  sram_stream_reader_if.master     bus,
  output logic                     o_busy,
  output logic                     done
`ifdef SRAM_STREAM_CHECKSUM_EN
  ,
  output logic [19:0]              o_sum
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(N_WORDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t            state_r;
  logic [ADDR_W-1:0] addr_r;
  logic [ADDR_W-1:0] acc_cnt_r;
  logic              inflight_r;
  logic [DATA_W-1:0] fifo_mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        cnt_r;
  logic              busy_r;
  logic              done_r;
`ifdef SRAM_STREAM_CHECKSUM_EN
  logic [19:0]       sum_r;
`endif

  logic              pop_s;
  logic              push_s;
  logic [1:0]        cnt_after_pop_s;
  logic              issue_s;

  assign pop_s  = (cnt_r != 2'd0) && bus.i_ready;
  assign push_s = inflight_r;

  // Read credit: a slot freed by this cycle's accept may be reused at once,
  // which is what lets a 2-entry FIFO sustain one word per cycle.
  always_comb begin
    cnt_after_pop_s = cnt_r;
    issue_s         = 1'b0;
    if (pop_s) begin
      cnt_after_pop_s = cnt_r - 2'd1;
    end else begin
      cnt_after_pop_s = cnt_r;
    end
    if ((state_r == ST_READ) && ((cnt_after_pop_s + {1'b0, inflight_r}) < 2'd2)) begin
      issue_s = 1'b1;
    end else begin
      issue_s = 1'b0;
    end
  end

  // The strobe must react to this cycle's accept to keep full throughput,
  // so it is decoded from registered state plus i_ready.
  assign bus.o_sram_cs   = issue_s;
  assign bus.o_sram_addr = addr_r;
  assign bus.o_valid     = (cnt_r != 2'd0);
  assign bus.o_data      = fifo_mem_r[rd_ptr_r];
  assign o_busy          = busy_r;
  assign done            = done_r;
`ifdef SRAM_STREAM_CHECKSUM_EN
  assign o_sum           = sum_r;
`endif

  // Run FSM, read address, FIFO and accepted-word bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      addr_r        <= '0;
      acc_cnt_r     <= '0;
      inflight_r    <= 1'b0;
      fifo_mem_r[0] <= '0;
      fifo_mem_r[1] <= '0;
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      cnt_r         <= 2'd0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
`ifdef SRAM_STREAM_CHECKSUM_EN
      sum_r         <= 20'd0;
`endif
    end else begin
      // Data for a read issued last cycle is on i_sram_rdata now.
      inflight_r <= issue_s;
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= bus.i_sram_rdata;
        wr_ptr_r             <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r  <= ~rd_ptr_r;
        acc_cnt_r <= acc_cnt_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end
      cnt_r  <= cnt_r + {1'b0, push_s} - {1'b0, pop_s};
      done_r <= 1'b0;
`ifdef SRAM_STREAM_CHECKSUM_EN
      if (pop_s) begin
        sum_r <= sum_r + 20'(bus.o_data);
      end
`endif

      case (state_r)
        ST_IDLE: begin
          if (i_en) begin
            state_r   <= ST_READ;
            addr_r    <= '0;
            acc_cnt_r <= '0;
            busy_r    <= 1'b1;
`ifdef SRAM_STREAM_CHECKSUM_EN
            sum_r     <= 20'd0;
`endif
          end
        end
        ST_READ: begin
          // The address is not advanced past the last word, so a full
          // 2^ADDR_W run never wraps the counter.
          if (issue_s) begin
            if (addr_r == LAST_ADDR) begin
              state_r <= ST_DRAIN;
            end else begin
              addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
            end
          end
        end
        ST_DRAIN: begin
          if (pop_s && (acc_cnt_r == LAST_ADDR)) begin
            state_r <= ST_DONE;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_stream_reader.sv
// ---------------------------------------------------------------------------
// tb_sram_stream_reader
// Directed bench for sram_stream_reader. Instance A streams 16 words
// (ADDR_W=4, so the last address is all-ones), instance B streams a single
// word. With SRAM_STREAM_CHECKSUM_EN defined, instance C streams 4096 words
// of 0xFF and its o_sum is compared.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_sram_stream_reader;

  logic clk;
  logic rst;
  logic en_a;
  logic en_b;
  logic ready;
  logic busy_a, done_a, busy_b, done_b;
`ifdef SRAM_STREAM_CHECKSUM_EN
  logic en_c;
  logic busy_c, done_c;
  logic [19:0] sum_a, sum_b, sum_c;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  logic [7:0] mem_a [16];

  sram_stream_reader_if #(.DATA_W(8), .ADDR_W(4)) if_a ();
  sram_stream_reader_if #(.DATA_W(8), .ADDR_W(4)) if_b ();

  assign if_a.i_ready = ready;
  assign if_b.i_ready = ready;

  sram_stream_reader #(.DATA_W(8), .ADDR_W(4), .N_WORDS(16)) dut_a (
    .clk(clk), .rst(rst), .i_en(en_a), .bus(if_a.master),
    .o_busy(busy_a), .done(done_a)
`ifdef SRAM_STREAM_CHECKSUM_EN
    , .o_sum(sum_a)
`endif
  );

  sram_stream_reader #(.DATA_W(8), .ADDR_W(4), .N_WORDS(1)) dut_b (
    .clk(clk), .rst(rst), .i_en(en_b), .bus(if_b.master),
    .o_busy(busy_b), .done(done_b)
`ifdef SRAM_STREAM_CHECKSUM_EN
    , .o_sum(sum_b)
`endif
  );

`ifdef SRAM_STREAM_CHECKSUM_EN
  sram_stream_reader_if #(.DATA_W(8), .ADDR_W(12)) if_c ();
  assign if_c.i_ready = ready;

  sram_stream_reader #(.DATA_W(8), .ADDR_W(12), .N_WORDS(4096)) dut_c (
    .clk(clk), .rst(rst), .i_en(en_c), .bus(if_c.master),
    .o_busy(busy_c), .done(done_c), .o_sum(sum_c)
  );

  // SRAM model for C: every word reads 0xFF.
  always @(posedge clk) begin
    if (if_c.o_sram_cs) if_c.i_sram_rdata <= 8'hFF;
  end
`endif

  // SRAM models: registered read, data valid the cycle after the strobe.
  always @(posedge clk) begin
    if (if_a.o_sram_cs) if_a.i_sram_rdata <= mem_a[if_a.o_sram_addr];
  end

  always @(posedge clk) begin
    if (if_b.o_sram_cs) if_b.i_sram_rdata <= 8'hA5;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Sampled view of the selected instance.
  logic       m_cs, m_valid, m_busy, m_done;
  logic [3:0] m_addr;
  logic [7:0] m_data;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int sel);
    m_cs    = (sel == 1) ? if_b.o_sram_cs   : if_a.o_sram_cs;
    m_addr  = (sel == 1) ? if_b.o_sram_addr : if_a.o_sram_addr;
    m_valid = (sel == 1) ? if_b.o_valid     : if_a.o_valid;
    m_data  = (sel == 1) ? if_b.o_data      : if_a.o_data;
    m_busy  = (sel == 1) ? busy_b           : busy_a;
    m_done  = (sel == 1) ? done_b           : done_a;
  endtask

  task automatic check_reset_state(input int sel);
    sample(sel);
    check_val("rst_cs",    {31'd0, m_cs},    32'd0);
    check_val("rst_addr",  {28'd0, m_addr},  32'd0);
    check_val("rst_valid", {31'd0, m_valid}, 32'd0);
    check_val("rst_data",  {24'd0, m_data},  32'd0);
    check_val("rst_busy",  {31'd0, m_busy},  32'd0);
    check_val("rst_done",  {31'd0, m_done},  32'd0);
  endtask

  // Start a run on instance sel and scoreboard it until the cycle after done.
  task automatic run_stream(input int sel, input int n, input bit bp, input bit hold_en,
                            input int exp_first, input int exp_done_t);
    logic [31:0] pat;
    int t, acc, issued, first_t, done_t, done_cnt, zero_reads;
    bit prev_v, prev_r, fin, found;
    logic [7:0] prev_d, expw;
    pat = 32'b1011_0010_1100_1101_0110_0011_1001_0100;
    t = 0; acc = 0; issued = 0; first_t = -1; done_t = -1; done_cnt = 0; zero_reads = 0;
    prev_v = 1'b0; prev_r = 1'b0; prev_d = 8'd0; fin = 1'b0; found = 1'b0;
    if (sel == 1) en_b = 1'b1; else en_a = 1'b1;
    tick();
    if (!hold_en) begin
      en_a = 1'b0;
      en_b = 1'b0;
    end
    while (!fin && t < 200) begin
      ready = bp ? pat[t % 32] : 1'b1;
      #1;
      sample(sel);
      if (m_cs) begin
        check_val("rd_addr", {28'd0, m_addr}, 32'(issued));
        check_val("outstanding_le2", {31'd0, (issued - acc) <= 2}, 32'd1);
        if (m_addr == 4'd0) zero_reads++;
        issued++;
      end
      if (prev_v && !prev_r) begin
        check_val("hold_valid", {31'd0, m_valid}, 32'd1);
        check_val("hold_data", {24'd0, m_data}, {24'd0, prev_d});
      end
      if (m_valid && first_t < 0) first_t = t;
      if (m_valid && ready) begin
        expw = (sel == 1) ? 8'hA5 : 8'(acc);
        check_val("data", {24'd0, m_data}, {24'd0, expw});
        acc++;
      end
      if (m_done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
      prev_v = m_valid; prev_r = ready; prev_d = m_data;
      if (done_t >= 0 && t > done_t) begin
        fin = 1'b1;
      end else begin
        tick();
        t++;
      end
    end
    check_val("run_finished", {31'd0, fin}, 32'd1);
    check_val("words_accepted", 32'(acc), 32'(n));
    check_val("reads_issued", 32'(issued), 32'(n));
    check_val("done_pulses", 32'(done_cnt), 32'd1);
    if (exp_first >= 0) check_val("first_valid_t", 32'(first_t), 32'(exp_first));
    if (exp_done_t >= 0) check_val("done_t", 32'(done_t), 32'(exp_done_t));
    if (hold_en) begin
      check_val("single_start", 32'(zero_reads), 32'd1);
      for (int k = 0; k < 3; k++) begin
        if (!found) begin
          tick();
          ready = 1'b1;
          #1;
          sample(sel);
          if (m_cs && m_addr == 4'd0) found = 1'b1;
        end
      end
      check_val("restart_after_done", {31'd0, found}, 32'd1);
      en_a = 1'b0;
      en_b = 1'b0;
    end
  endtask

  initial begin
    int acc;
    for (int i = 0; i < 16; i++) mem_a[i] = 8'(i);
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0; ready = 1'b1;
`ifdef SRAM_STREAM_CHECKSUM_EN
    en_c = 1'b0;
`endif
    repeat (3) tick();
    #1;
    check_reset_state(0);
    check_reset_state(1);
`ifdef SRAM_STREAM_CHECKSUM_EN
    check_val("rst_sum", {12'd0, sum_c}, 32'd0);
`endif
    rst = 1'b0;
    tick();

    // Basic full-rate run, 16 words, last address all-ones.
    run_stream(0, 16, 1'b0, 1'b0, 2, 18);
    repeat (2) tick();

    // Backpressure with a fixed ~50% ready pattern.
    run_stream(0, 16, 1'b1, 1'b0, -1, -1);
    ready = 1'b1;
    repeat (2) tick();

    // Single-word run.
    run_stream(1, 1, 1'b0, 1'b0, 2, 3);
    repeat (2) tick();

    // Reset after five accepted words.
    acc = 0;
    en_a = 1'b1;
    tick();
    en_a = 1'b0;
    for (int k = 0; k < 50; k++) begin
      if (acc < 5) begin
        ready = 1'b1;
        #1;
        sample(0);
        if (m_valid && ready) acc++;
        if (acc < 5) tick();
      end
    end
    check_val("mid_accepted", 32'(acc), 32'd5);
    rst = 1'b1;
    tick();
    #1;
    check_reset_state(0);
    rst = 1'b0;
    tick();
    #1;
    sample(0);
    check_val("post_rst_discard", {31'd0, m_valid}, 32'd0);
    tick();
    run_stream(0, 16, 1'b0, 1'b0, 2, 18);
    repeat (2) tick();

    // i_en held high across a run.
    run_stream(0, 16, 1'b0, 1'b1, 2, 18);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();

`ifdef SRAM_STREAM_CHECKSUM_EN
    begin
      bit seen;
      seen = 1'b0;
      ready = 1'b1;
      en_c = 1'b1;
      tick();
      en_c = 1'b0;
      for (int k = 0; k < 6000; k++) begin
        if (!seen) begin
          #1;
          if (done_c) seen = 1'b1;
          else tick();
        end
      end
      check_val("sum_done_seen", {31'd0, seen}, 32'd1);
      check_val("sum_at_done", {12'd0, sum_c}, 32'h000F_F000);
      repeat (3) tick();
      check_val("sum_held", {12'd0, sum_c}, 32'h000F_F000);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
